// File: rtl/sub32_multicycle.sv
// Chunked multi-cycle subtractor: diff = a - b - bin, CHUNK bits per clock,
// borrow rippled between chunks through a register, valid/ready on both sides.
module sub32_multicycle #(
    parameter int unsigned N     = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         zero,
    output logic         ovf,
    output logic         done_valid,
    input  logic         done_ready
);

    localparam int unsigned NCH = N / CHUNK;
    localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned BW  = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic            borrow_q;
    logic [IW-1:0]   idx_q;
    logic [N-1:0]    diff_q;
    logic            bout_q;
    logic            zero_q;
    logic            ovf_q;
    logic            done_valid_q;

    logic [BW-1:0]    base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   sub_w;
    logic [N-1:0]     diff_d;
    logic             borrow_d;
    logic             zero_d;
    logic             ovf_d;

    // One chunk per cycle; flags are derived from the diff as it will look
    // after this chunk is written, so the last cycle yields final flags.
    always_comb begin
        base     = BW'(32'(idx_q) * CHUNK);
        a_chunk  = a_q[base +: CHUNK];
        b_chunk  = b_q[base +: CHUNK];
        sub_w    = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK{1'b0}}, borrow_q};
        diff_d   = diff_q;
        diff_d[base +: CHUNK] = sub_w[CHUNK-1:0];
        borrow_d = sub_w[CHUNK];
        zero_d   = (diff_d == '0);
        ovf_d    = (a_q[N-1] != b_q[N-1]) && (diff_d[N-1] != a_q[N-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            borrow_q     <= 1'b0;
            idx_q        <= '0;
            diff_q       <= '0;
            bout_q       <= 1'b0;
            zero_q       <= 1'b0;
            ovf_q        <= 1'b0;
            done_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= bin;
                        idx_q    <= '0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    diff_q   <= diff_d;
                    borrow_q <= borrow_d;
                    if (idx_q == LAST) begin
                        idx_q        <= '0;
                        bout_q       <= borrow_d;
                        zero_q       <= zero_d;
                        ovf_q        <= ovf_d;
                        done_valid_q <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        done_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    done_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign start_ready = (state_q == IDLE);
    assign done_valid  = done_valid_q;
    assign diff        = diff_q;
    assign bout        = bout_q;
    assign zero        = zero_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_sub32_multicycle.sv
// Directed-vector and random bench for sub32_multicycle.
// Expected values come from hand-computed tables and a 33-bit reference subtract.
module tb_sub32_multicycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;
    logic        done_valid;
    logic        done_ready;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    sub32_multicycle #(.N(32), .CHUNK(8)) dut (
        .clk(clk),
        .rst(rst),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .a(a),
        .b(b),
        .bin(bin),
        .diff(diff),
        .bout(bout),
        .zero(zero),
        .ovf(ovf),
        .done_valid(done_valid),
        .done_ready(done_ready)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] diff;
        logic        bout;
        logic        zero;
        logic        ovf;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else
            passed++;
    endtask

    // Presents operands, waits for acceptance and completion; lat counts edges
    // from the accept edge to done_valid.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                         input logic ibin, output int lat);
        int w;
        @(negedge clk);
        a           = ia;
        b           = ib;
        bin         = ibin;
        start_valid = 1'b1;
        w = 0;
        while (!start_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!start_ready) chk("accept_timeout", 64'(start_ready), 64'd1);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        lat = 0;
        while (!done_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done_valid) chk("done_timeout", 64'(done_valid), 64'd1);
    endtask

    task automatic consume();
        @(negedge clk);
        done_ready = 1'b1;
        @(posedge clk);
        #1;
        done_ready = 1'b0;
    endtask

    initial begin
        vec_t        vt[$];
        int          lat;
        logic [32:0] ref_w;
        logic [31:0] ra, rb, hd;
        logic        rbin, ro, hb, hz, ho;

        vt.push_back('{32'd5, 32'd3, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0});
        vt.push_back('{32'h00000100, 32'h1, 1'b0, 32'h000000FF, 1'b0, 1'b0, 1'b0});
        vt.push_back('{32'h0, 32'h1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0});
        vt.push_back('{32'h80000000, 32'h1, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1});
        vt.push_back('{32'h12345678, 32'h12345677, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0});
        vt.push_back('{32'h00000055, 32'h00000055, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0});
        vt.push_back('{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b1});
        vt.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0});
        vt.push_back('{32'h00FF0000, 32'h00000001, 1'b1, 32'h00FEFFFE, 1'b0, 1'b0, 1'b0});

        rst         = 1'b1;
        start_valid = 1'b0;
        done_ready  = 1'b0;
        a           = '0;
        b           = '0;
        bin         = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_start_ready", 64'(start_ready), 64'd1);
        chk("rst_done_valid", 64'(done_valid), 64'd0);
        chk("rst_diff", 64'(diff), 64'd0);
        chk("rst_flags", 64'({bout, zero, ovf}), 64'd0);
        rst = 1'b0;

        foreach (vt[i]) begin
            issue(vt[i].a, vt[i].b, vt[i].bin, lat);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'd4);
            chk($sformatf("v%0d_diff", i), 64'(diff), 64'(vt[i].diff));
            chk($sformatf("v%0d_bout", i), 64'(bout), 64'(vt[i].bout));
            chk($sformatf("v%0d_zero", i), 64'(zero), 64'(vt[i].zero));
            chk($sformatf("v%0d_ovf", i), 64'(ovf), 64'(vt[i].ovf));
            consume();
            chk($sformatf("v%0d_idle_ready", i), 64'(start_ready), 64'd1);
            chk($sformatf("v%0d_idle_dv", i), 64'(done_valid), 64'd0);
            chk($sformatf("v%0d_hold_bout", i), 64'(bout), 64'(vt[i].bout));
        end

        // Backpressure: result held, new operands ignored until handshake.
        issue(32'd100, 32'd1, 1'b0, lat);
        hd = diff;
        hb = bout;
        hz = zero;
        ho = ovf;
        chk("bp_diff0", 64'(hd), 64'd99);
        @(negedge clk);
        a           = 32'd7;
        b           = 32'd2;
        bin         = 1'b0;
        start_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_diff", c), 64'(diff), 64'(hd));
            chk($sformatf("bp%0d_flags", c), 64'({bout, zero, ovf}),
                64'({hb, hz, ho}));
            chk($sformatf("bp%0d_ready", c), 64'(start_ready), 64'd0);
            chk($sformatf("bp%0d_dv", c), 64'(done_valid), 64'd1);
        end
        done_ready = 1'b1;
        @(posedge clk);
        #1;
        done_ready = 1'b0;
        chk("bp_idle_ready", 64'(start_ready), 64'd1);
        chk("bp_idle_dv", 64'(done_valid), 64'd0);
        chk("bp_idle_diff", 64'(diff), 64'(hd));
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        chk("bp_accept", 64'(start_ready), 64'd0);
        lat = 0;
        while (!done_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp_new_lat", 64'(lat), 64'd4);
        chk("bp_new_diff", 64'(diff), 64'd5);
        consume();

        // Leave bout=1 behind, then reset asynchronously with index at 2.
        issue(32'd0, 32'd1, 1'b0, lat);
        chk("pre_rst_bout", 64'(bout), 64'd1);
        consume();
        @(negedge clk);
        a           = 32'hFFFFFFFF;
        b           = 32'h1;
        bin         = 1'b0;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_dv", 64'(done_valid), 64'd0);
        chk("mid_rst_ready", 64'(start_ready), 64'd1);
        chk("mid_rst_diff", 64'(diff), 64'd0);
        chk("mid_rst_flags", 64'({bout, zero, ovf}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(32'd10, 32'd4, 1'b0, lat);
        chk("post_rst_lat", 64'(lat), 64'd4);
        chk("post_rst_diff", 64'(diff), 64'd6);
        consume();

        for (int n = 0; n < 1000; n++) begin
            ra   = $urandom;
            rb   = ($urandom_range(0, 7) == 0) ? ra : $urandom;
            rbin = 1'($urandom_range(0, 1));
            ref_w = {1'b0, ra} - {1'b0, rb} - {32'd0, rbin};
            ro    = (ra[31] != rb[31]) && (ref_w[31] != ra[31]);
            issue(ra, rb, rbin, lat);
            chk($sformatf("rnd%0d", n),
                {29'd0, ref_w[31:0], ref_w[32], ref_w[31:0] == 32'd0, ro},
                {29'd0, diff, bout, zero, ovf});
            consume();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
